spi_xfer_buf: RTL and testbench

SPI_XFER_BUF -- requirements
Module: spi_xfer_buf

---
 rtl/spi_xfer_buf.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_xfer_buf.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_buf.sv
// -----------------------------------------------------------------------------
// spi_xfer_buf
//   Byte buffering between an SPI slave shift register and a host bus.
//   - RX FIFO: captures every byte the SPI slave completes (rising spi_rdy).
//   - TX FIFO: host-written bytes, handed to the SPI slave by a two-state
//     loader (ARM waits for a byte to load, LOADED waits for it to shift out).
//   - Sticky rx_ovf / tx_udr error flags, cleared by err_clr (set wins).
//   - frame_end pulses once per frame on the synchronized rising edge of ss.
//
//   Optional feature: define SPI_XFER_BUF_LEVEL_EN to add the rx_level and
//   tx_level occupancy outputs. Without it the block is complete and those
//   ports are absent.
// -----------------------------------------------------------------------------
module spi_xfer_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // SPI slave side
  input  logic                  ss,
  input  logic                  spi_rdy,
  input  logic [DATA_WIDTH-1:0] spi_data_o,
  output logic                  spi_ld,
  output logic [DATA_WIDTH-1:0] spi_data_i,
  // Host RX port
  input  logic                  rx_rd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_empty,
  output logic                  rx_full,
  // Host TX port
  input  logic                  tx_wr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_empty,
  output logic                  tx_full,
  // Status
  output logic                  rx_ovf,
  output logic                  tx_udr,
  output logic                  frame_end,
`ifdef SPI_XFER_BUF_LEVEL_EN
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic [DEPTH_LOG2:0]   tx_level,
`endif
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One extra pointer bit separates "full" from "empty" when the indices match.
  typedef logic [DEPTH_LOG2:0] ptr_t;

  typedef enum logic {
    ST_ARM    = 1'b0,  // SPI slave needs a byte
    ST_LOADED = 1'b1   // SPI slave holds a byte not yet shifted out
  } ld_state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic                  ss_meta_q, ss_sync_q, ss_prev_q;
  logic                  rdy_prev_q;
  logic                  byte_evt;

  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  ptr_t                  rx_wr_ptr_q, rx_wr_ptr_d;
  ptr_t                  rx_rd_ptr_q, rx_rd_ptr_d;
  logic                  rx_push, rx_pop;

  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  ptr_t                  tx_wr_ptr_q, tx_wr_ptr_d;
  ptr_t                  tx_rd_ptr_q, tx_rd_ptr_d;
  logic                  tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  ld_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;

  logic                  rx_ovf_q, rx_ovf_d, rx_ovf_set;
  logic                  tx_udr_q, tx_udr_d, tx_udr_set;

  // ---------------------------------------------------------------------------
  // ss synchronizer plus history flop; resets to bus-idle (high)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; with = the chain would collapse.
    if (!rst) begin
      ss_meta_q <= 1'b1;
      ss_sync_q <= 1'b1;
      ss_prev_q <= 1'b1;
    end else begin
      ss_meta_q <= ss;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
    end
  end

  // Frame end is the synchronized low-to-high transition of ss.
  assign frame_end = ss_sync_q & ~ss_prev_q;

  // ---------------------------------------------------------------------------
  // spi_rdy history for rising-edge byte detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) rdy_prev_q <= 1'b0;
    else      rdy_prev_q <= spi_rdy;
  end

  // A held-high spi_rdy yields only the first-cycle event.
  assign byte_evt = spi_rdy & ~rdy_prev_q;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
  assign rx_full  = (rx_wr_ptr_q[DEPTH_LOG2] != rx_rd_ptr_q[DEPTH_LOG2]) &&
                    (rx_wr_ptr_q[DEPTH_LOG2-1:0] == rx_rd_ptr_q[DEPTH_LOG2-1:0]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_push    = byte_evt & (~rx_full | rx_pop);
  assign rx_ovf_set = byte_evt & ~rx_push;

  // First-word fall-through: the head entry is always visible.
  assign rx_data = rx_mem_q[rx_rd_ptr_q[DEPTH_LOG2-1:0]];

  // RX pointer next-state
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + ptr_t'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + ptr_t'(rx_pop);
  end

  // RX pointer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; pointer reset alone makes their
    // contents unreachable, and leaving them unreset lets them map to RAM.
    if (rx_push) rx_mem_q[rx_wr_ptr_q[DEPTH_LOG2-1:0]] <= spi_data_o;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
  assign tx_full  = (tx_wr_ptr_q[DEPTH_LOG2] != tx_rd_ptr_q[DEPTH_LOG2]) &&
                    (tx_wr_ptr_q[DEPTH_LOG2-1:0] == tx_rd_ptr_q[DEPTH_LOG2-1:0]);

  // Writes to a full TX FIFO are dropped.
  assign tx_push = tx_wr & ~tx_full;
  assign tx_head = tx_mem_q[tx_rd_ptr_q[DEPTH_LOG2-1:0]];

  // TX pointer next-state
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + ptr_t'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + ptr_t'(tx_pop);
  end

  // TX pointer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
    end
  end

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q[DEPTH_LOG2-1:0]] <= tx_data;
  end

  // ---------------------------------------------------------------------------
  // TX loader FSM: next state, load strobe and underrun detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    spi_ld     = 1'b0;
    tx_pop     = 1'b0;
    tx_udr_set = 1'b0;
    unique case (state_q)
      ST_ARM: begin
        if (!tx_empty) begin
          spi_ld  = 1'b1;
          tx_pop  = 1'b1;
          state_d = ST_LOADED;
        end else if (byte_evt) begin
          // The slave shifted out a byte with nothing new loaded.
          tx_udr_set = 1'b1;
        end
      end
      ST_LOADED: begin
        // Returning to ARM defers the next load to the following cycle.
        if (byte_evt) state_d = ST_ARM;
      end
      default: state_d = ST_ARM;
    endcase
  end

  // The load port shows the TX head while loading, else the last loaded byte.
  assign spi_data_d = spi_ld ? tx_head : spi_data_q;
  assign spi_data_i = spi_data_d;

  // Loader state and held load data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ARM;
      spi_data_q <= '0;
    end else begin
      state_q    <= state_d;
      spi_data_q <= spi_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as err_clr wins
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~err_clr);
    tx_udr_d = tx_udr_set | (tx_udr_q & ~err_clr);
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ovf_q <= 1'b0;
      tx_udr_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_udr_q <= tx_udr_d;
    end
  end

  assign rx_ovf = rx_ovf_q;
  assign tx_udr = tx_udr_q;

  // ---------------------------------------------------------------------------
  // Optional occupancy outputs; the pointer difference wraps naturally
  // ---------------------------------------------------------------------------
`ifdef SPI_XFER_BUF_LEVEL_EN
  assign rx_level = rx_wr_ptr_q - rx_rd_ptr_q;
  assign tx_level = tx_wr_ptr_q - tx_rd_ptr_q;
`endif

endmodule

// File: tb/tb_spi_xfer_buf.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_buf
//   Self-checking bench for spi_xfer_buf. A queue-based model tracks what the
//   outputs must be; one compare process checks them every cycle, and directed
//   scenarios add hand-computed literal expectations. Randomized traffic
//   follows the directed part.
// -----------------------------------------------------------------------------
module tb_spi_xfer_buf;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          ss;
  logic          spi_rdy;
  logic [DW-1:0] spi_data_o;
  logic          spi_ld;
  logic [DW-1:0] spi_data_i;
  logic          rx_rd;
  logic [DW-1:0] rx_data;
  logic          rx_empty, rx_full;
  logic          tx_wr;
  logic [DW-1:0] tx_data;
  logic          tx_empty, tx_full;
  logic          rx_ovf, tx_udr, frame_end;
  logic          err_clr;
`ifdef SPI_XFER_BUF_LEVEL_EN
  logic [DL:0]   rx_level, tx_level;
`endif

  int n_vec = 0;
  int n_err = 0;

  spi_xfer_buf #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .spi_rdy    (spi_rdy),
    .spi_data_o (spi_data_o),
    .spi_ld     (spi_ld),
    .spi_data_i (spi_data_i),
    .rx_rd      (rx_rd),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .tx_full    (tx_full),
    .rx_ovf     (rx_ovf),
    .tx_udr     (tx_udr),
    .frame_end  (frame_end),
`ifdef SPI_XFER_BUF_LEVEL_EN
    .rx_level   (rx_level),
    .tx_level   (tx_level),
`endif
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: FIFOs as queues, loader as "slave holds a byte" flag,
  // ss seen through the last three clock samples.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  bit            m_valid = 1'b0;
  bit            m_rdy_prev, m_loaded, m_ovf, m_udr;
  logic [DW-1:0] m_last;
  bit [2:0]      m_ss;   // [0] newest sample of ss, [2] oldest

  task automatic model_step();
    bit evt, pop, push, ld, tx_was_full, tx_was_empty;
    if (!rst) begin
      rxq.delete();
      txq.delete();
      m_rdy_prev = 1'b0;
      m_loaded   = 1'b0;
      m_ovf      = 1'b0;
      m_udr      = 1'b0;
      m_last     = '0;
      m_ss       = 3'b111;
      m_valid    = 1'b1;
      return;
    end
    if (!m_valid) return;
    evt          = spi_rdy && !m_rdy_prev;
    pop          = rx_rd && (rxq.size() > 0);
    push         = evt && ((rxq.size() < DEPTH) || pop);
    tx_was_full  = (txq.size() == DEPTH);
    tx_was_empty = (txq.size() == 0);
    ld           = !m_loaded && !tx_was_empty;
    m_ovf = (evt && !push) || (m_ovf && !err_clr);
    m_udr = (evt && !m_loaded && tx_was_empty) || (m_udr && !err_clr);
    if (pop)  void'(rxq.pop_front());
    if (push) rxq.push_back(spi_data_o);
    if (ld) begin
      m_last = txq[0];
      void'(txq.pop_front());
    end
    if (tx_wr && !tx_was_full) txq.push_back(tx_data);
    if (ld)       m_loaded = 1'b1;
    else if (evt) m_loaded = 1'b0;
    m_rdy_prev = spi_rdy;
    m_ss       = {m_ss[1:0], ss};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs are checked mid-cycle against the model.
  initial forever begin
    bit exp_ld;
    @(negedge clk);
    if (m_valid) begin
      exp_ld = !m_loaded && (txq.size() > 0);
      check("spi_ld", spi_ld, exp_ld);
      check("spi_data_i", spi_data_i, exp_ld ? txq[0] : m_last);
      check("rx_empty", rx_empty, rxq.size() == 0);
      check("rx_full", rx_full, rxq.size() == DEPTH);
      if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
      check("tx_empty", tx_empty, txq.size() == 0);
      check("tx_full", tx_full, txq.size() == DEPTH);
      check("rx_ovf", rx_ovf, m_ovf);
      check("tx_udr", tx_udr, m_udr);
      check("frame_end", frame_end, m_ss[1] && !m_ss[2]);
`ifdef SPI_XFER_BUF_LEVEL_EN
      check("rx_level", rx_level, rxq.size());
      check("tx_level", tx_level, txq.size());
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spi_rdy    = 1'b0;
    spi_data_o = '0;
    rx_rd      = 1'b0;
    tx_wr      = 1'b0;
    tx_data    = '0;
    err_clr    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ss  = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic byte_event(input logic [DW-1:0] d);
    spi_data_o = d;
    spi_rdy    = 1'b1;
    tick();
    spi_rdy    = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    int fe_cnt, fe_first;
    int rd_pct, wr_pct, rdy_pct;

    idle_inputs();
    ss  = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_spi_ld", spi_ld, 0);
    check("rst_spi_data_i", spi_data_i, 8'h00);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_full", rx_full, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_flags", {rx_ovf, tx_udr, frame_end}, 3'b000);
    rst = 1'b1;
    tick();

    // Single TX byte loads one cycle after the write
    tx_wr   = 1'b1;
    tx_data = 8'hA5;
    tick();
    tx_wr   = 1'b0;
    check("a5_ld_pulse", spi_ld, 1);
    check("a5_ld_data", spi_data_i, 8'hA5);
    tick();
    check("a5_ld_done", spi_ld, 0);
    check("a5_tx_empty", tx_empty, 1);
    check("a5_data_hold", spi_data_i, 8'hA5);

    // RX fill to full, overflow on the 17th, in-order drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) byte_event(i[DW-1:0]);
    check("fill_full", rx_full, 1);
    check("fill_no_ovf", rx_ovf, 0);
    byte_event(8'h10);
    check("ovf_full", rx_full, 1);
    check("ovf_set", rx_ovf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", rx_data, i);
      rx_rd = 1'b1;
      tick();
      rx_rd = 1'b0;
    end
    check("drain_empty", rx_empty, 1);

    // Push and pop together on a full RX FIFO
    do_reset();
    for (int i = 0; i < DEPTH; i++) byte_event(8'h40 + i[DW-1:0]);
    spi_data_o = 8'h55;
    spi_rdy    = 1'b1;
    rx_rd      = 1'b1;
    tick();
    spi_rdy    = 1'b0;
    rx_rd      = 1'b0;
    check("pp_no_ovf", rx_ovf, 0);
    check("pp_full", rx_full, 1);
    check("pp_head", rx_data, 8'h41);

    // Underrun, clear, and clear coincident with a new underrun
    do_reset();
    spi_data_o = 8'h11;
    spi_rdy    = 1'b1;
    tick();
    check("udr_set", tx_udr, 1);
    spi_rdy    = 1'b0;
    tick();
    err_clr    = 1'b1;
    tick();
    err_clr    = 1'b0;
    check("udr_clr", tx_udr, 0);
    err_clr    = 1'b1;
    spi_rdy    = 1'b1;
    tick();
    err_clr    = 1'b0;
    spi_rdy    = 1'b0;
    check("udr_set_wins", tx_udr, 1);
    tick();

    // Frame of three bytes, frame_end after ss release
    do_reset();
    fe_cnt   = 0;
    fe_first = -1;
    ss = 1'b0;
    for (int b = 0; b < 3; b++) begin
      spi_data_o = 8'hC0 + b[DW-1:0];
      spi_rdy    = 1'b1;
      tick();
      if (frame_end) fe_cnt++;
      spi_rdy    = 1'b0;
      tick();
      if (frame_end) fe_cnt++;
    end
    ss = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (frame_end) begin
        fe_cnt++;
        if (fe_first < 0) fe_first = j;
      end
    end
    check("frame_end_count", fe_cnt, 1);
    check("frame_end_delay", (fe_first >= 2) && (fe_first <= 3), 1);

    // spi_rdy held high for 5 cycles is one byte
    do_reset();
    spi_data_o = 8'h9C;
    spi_rdy    = 1'b1;
    repeat (5) tick();
    spi_rdy    = 1'b0;
    tick();
    check("held_rdy_one", rx_empty, 0);
    check("held_rdy_data", rx_data, 8'h9C);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    check("held_rdy_only", rx_empty, 1);

    // Reset with entries in both FIFOs
    do_reset();
    for (int i = 0; i < 3; i++) byte_event(8'h20 + i[DW-1:0]);
    tx_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'h30 + i[DW-1:0];
      tick();
    end
    tx_wr = 1'b0;
    check("pre_rst_rx", rx_empty, 0);
    check("pre_rst_tx", tx_empty, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_rx_empty", rx_empty, 1);
    check("mid_rst_tx_empty", tx_empty, 1);
    check("mid_rst_spi_ld", spi_ld, 0);
    check("mid_rst_data", spi_data_i, 8'h00);
    check("mid_rst_flags", {rx_ovf, tx_udr, rx_full, tx_full}, 4'b0000);
    rst   = 1'b1;
    tick();
    tx_wr   = 1'b1;
    tx_data = 8'h3C;
    tick();
    tx_wr   = 1'b0;
    check("post_rst_ld", spi_ld, 1);
    check("post_rst_data", spi_data_i, 8'h3C);
    byte_event(8'h77);
    check("post_rst_rx_push", rx_data, 8'h77);

    // Randomized traffic in phases biased toward fill, drain and mixed
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      case ((cyc / 500) % 4)
        0:       begin rd_pct = 10; wr_pct = 70; rdy_pct = 40; end
        1:       begin rd_pct = 80; wr_pct = 10; rdy_pct = 20; end
        2:       begin rd_pct = 40; wr_pct = 40; rdy_pct = 30; end
        default: begin rd_pct = 20; wr_pct = 20; rdy_pct = 70; end
      endcase
      rx_rd      = ($urandom_range(0, 99) < rd_pct);
      tx_wr      = ($urandom_range(0, 99) < wr_pct);
      spi_rdy    = ($urandom_range(0, 99) < rdy_pct);
      spi_data_o = DW'($urandom);
      tx_data    = DW'($urandom);
      err_clr    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) ss = ~ss;
      rst        = ($urandom_range(0, 599) != 0);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
